// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared types and address defaults for the memory access unit
package mem_access_unit_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {FLT_NONE = 2'd0, FLT_ALIGN = 2'd1, FLT_TIMEOUT = 2'd2} flt_t;
  localparam logic [15:0] EXC_RET_DEF = 16'hFFFF;
  localparam logic [15:0] PSW_ADDR_DEF = 16'hFFFC;
endpackage

// File: rtl/mem_access_unit_lane_steer.sv
// lane_steer: lane decode, alignment check and byte steering between CPU and memory words
module lane_steer #(
  parameter int WORD = 16
) (
  input  logic [WORD-1:0]               addr,
  input  logic                          byte_en,
  input  logic [WORD-1:0]               wdata,
  input  logic [$clog2(WORD/8)-1:0]     rd_lane,
  input  logic                          rd_byte,
  input  logic [WORD-1:0]               mem_rdata,
  output logic [$clog2(WORD/8)-1:0]     lane,
  output logic                          misaligned,
  output logic [WORD/8-1:0]             lanes,
  output logic [WORD-1:0]               mem_wdata,
  output logic [WORD-1:0]               rdata
);
  localparam int LANES = WORD / 8;
  localparam int LW = $clog2(LANES);
  logic [WORD-1:0] shifted;
  assign lane = addr[LW-1:0];
  assign misaligned = !byte_en && lane != '0;
  assign lanes = byte_en ? LANES'(1) << lane : '1;
  assign mem_wdata = byte_en ? {LANES{wdata[7:0]}} : wdata;
  // read lane is the one latched at acceptance, not the live address
  assign shifted = mem_rdata >> {rd_lane, 3'b000};
  assign rdata = rd_byte ? WORD'(shifted[7:0]) : mem_rdata;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU-side load/store sequencer with alignment check, special addresses and timeout
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int              WORD     = 16,
  parameter int              LANES    = WORD / 8,
  parameter logic [WORD-1:0] EXC_RET  = WORD'(EXC_RET_DEF),
  parameter logic [WORD-1:0] PSW_ADDR = WORD'(PSW_ADDR_DEF),
  parameter int              TIMEOUT  = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic             byteEn_i,
  input  logic [WORD-1:0]  addr_i,
  input  logic [WORD-1:0]  wdata_i,
  output logic             busy_o,
  output logic             ack_o,
  output logic [WORD-1:0]  rdata_o,
  output logic             fault_o,
  output logic [1:0]       faultCode_o,
  output logic             pswAddr_o,
  output logic             excRet_o,
  output logic             memReq_o,
  output logic             memWe_o,
  output logic [WORD-1:0]  memAddr_o,
  output logic [LANES-1:0] memLanes_o,
  output logic [WORD-1:0]  memWdata_o,
  input  logic [WORD-1:0]  memRdata_i,
  input  logic             memRdy_i
);
  localparam int LW = $clog2(LANES);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] lane, lane_q;
  logic byte_q, misaligned, is_exc, is_psw;
  logic [LANES-1:0] lanes;
  logic [WORD-1:0] steer_wdata, steer_rdata;
  lane_steer #(.WORD(WORD)) u_steer (
    .addr(addr_i),
    .byte_en(byteEn_i),
    .wdata(wdata_i),
    .rd_lane(lane_q),
    .rd_byte(byte_q),
    .mem_rdata(memRdata_i),
    .lane(lane),
    .misaligned(misaligned),
    .lanes(lanes),
    .mem_wdata(steer_wdata),
    .rdata(steer_rdata)
  );
  assign is_exc = addr_i == EXC_RET;
  assign is_psw = addr_i == PSW_ADDR;
  assign busy_o = state != S_IDLE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt <= '0;
      ack_o <= 1'b0;
      rdata_o <= '0;
      fault_o <= 1'b0;
      faultCode_o <= FLT_NONE;
      pswAddr_o <= 1'b0;
      excRet_o <= 1'b0;
      memReq_o <= 1'b0;
      memWe_o <= 1'b0;
      memAddr_o <= '0;
      memLanes_o <= '0;
      memWdata_o <= '0;
      lane_q <= '0;
      byte_q <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      case (state)
        S_IDLE: if (req_i) begin
          // alignment fault takes precedence over the special-address match
          if (misaligned || is_exc || is_psw) begin
            state <= S_DONE;
            ack_o <= 1'b1;
            rdata_o <= '0;
            fault_o <= misaligned;
            faultCode_o <= misaligned ? FLT_ALIGN : FLT_NONE;
            pswAddr_o <= !misaligned && is_psw;
            excRet_o <= !misaligned && is_exc;
          end else begin
            state <= S_WAIT;
            cnt <= '0;
            memReq_o <= 1'b1;
            memWe_o <= we_i;
            memAddr_o <= addr_i & ~WORD'(LANES - 1);
            memLanes_o <= lanes;
            memWdata_o <= steer_wdata;
            lane_q <= lane;
            byte_q <= byteEn_i;
          end
        end
        S_WAIT: begin
          if (!memRdy_i) cnt <= cnt + 1'b1;
          // a ready on the final wait cycle still completes cleanly
          if (memRdy_i || cnt == T_LAST) begin
            state <= S_DONE;
            ack_o <= 1'b1;
            memReq_o <= 1'b0;
            rdata_o <= memRdy_i && !memWe_o ? steer_rdata : '0;
            fault_o <= !memRdy_i;
            faultCode_o <= memRdy_i ? FLT_NONE : FLT_TIMEOUT;
            pswAddr_o <= 1'b0;
            excRet_o <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven scoreboard bench for mem_access_unit (WORD=16 and WORD=32 builds)
module tb_mem_access_unit;
  localparam int TIMEOUT = 15;
  typedef struct {
    logic        we;
    logic        byte_en;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        mem;
    int          rdy_at;
    logic [15:0] mrd;
    logic [15:0] maddr;
    logic [1:0]  lanes;
    logic [15:0] mwdata;
    logic        chk_rd;
    logic [15:0] rdata;
    logic        fault;
    logic [1:0]  code;
    logic        psw;
    logic        exc;
  } vec_t;
  logic clk = 0, rst = 1;
  logic req = 0, we = 0, byte_en = 0, mem_rdy = 0;
  logic [15:0] addr = 0, wdata = 0, mem_rdata = 0;
  logic busy, ack, fault, psw, exc, mem_req, mem_we;
  logic [1:0] code, mem_lanes;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic w_req = 0, w_byte = 0, w_rdy = 0;
  logic [31:0] w_addr = 0, w_mrd = 0;
  logic w_busy, w_ack, w_fault, w_psw, w_exc, w_mreq, w_mwe;
  logic [1:0] w_code;
  logic [3:0] w_lanes;
  logic [31:0] w_rdata, w_maddr, w_mwdata;
  int checks = 0, errors = 0;
  vec_t vecs[13];
  vec_t exp_q[$];
  always #5 clk = ~clk;
  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .byteEn_i(byte_en),
    .addr_i(addr), .wdata_i(wdata), .busy_o(busy), .ack_o(ack), .rdata_o(rdata),
    .fault_o(fault), .faultCode_o(code), .pswAddr_o(psw), .excRet_o(exc),
    .memReq_o(mem_req), .memWe_o(mem_we), .memAddr_o(mem_addr), .memLanes_o(mem_lanes),
    .memWdata_o(mem_wdata), .memRdata_i(mem_rdata), .memRdy_i(mem_rdy)
  );
  mem_access_unit #(.WORD(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .req_i(w_req), .we_i(1'b0), .byteEn_i(w_byte),
    .addr_i(w_addr), .wdata_i(32'h0), .busy_o(w_busy), .ack_o(w_ack), .rdata_o(w_rdata),
    .fault_o(w_fault), .faultCode_o(w_code), .pswAddr_o(w_psw), .excRet_o(w_exc),
    .memReq_o(w_mreq), .memWe_o(w_mwe), .memAddr_o(w_maddr), .memLanes_o(w_lanes),
    .memWdata_o(w_mwdata), .memRdata_i(w_mrd), .memRdy_i(w_rdy)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {24'h0, ack, busy, fault, code, psw, exc, mem_req, mem_we}, 32'h0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_maddr"}, mem_addr, 0);
    check({tag, "_mlanes"}, mem_lanes, 0);
    check({tag, "_mwdata"}, mem_wdata, 0);
  endtask
  task automatic score();
    vec_t e;
    check("ack", ack, 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("fault", fault, e.fault);
    check("fault_code", code, e.code);
    check("psw_flag", psw, e.psw);
    check("exc_flag", exc, e.exc);
    if (e.chk_rd) check("rdata", rdata, e.rdata);
  endtask
  task automatic run_vec(input vec_t v);
    int last;
    @(negedge clk);
    req = 1; we = v.we; byte_en = v.byte_en; addr = v.addr; wdata = v.wdata;
    exp_q.push_back(v);
    @(negedge clk);
    req = 0;
    if (!v.mem) begin
      check("no_mem_req", mem_req, 0);
      check("done_busy", busy, 1);
      score();
    end else begin
      check("wait_busy", busy, 1);
      check("wait_addr", mem_addr, v.maddr);
      check("wait_lanes", mem_lanes, v.lanes);
      check("wait_we", mem_we, v.we);
      if (v.we) check("wait_wdata", mem_wdata, v.mwdata);
      last = v.rdy_at == 0 ? TIMEOUT : v.rdy_at;
      for (int k = 1; k <= last; k++) begin
        if (k == last) begin
          check("wait_no_ack", ack, 0);
          check("wait_req", mem_req, 1);
        end
        req = 1; addr = 16'h0003;
        mem_rdy = v.rdy_at == k; mem_rdata = v.mrd;
        @(negedge clk);
      end
      req = 0; mem_rdy = 0; mem_rdata = 16'($urandom);
      check("req_drop", mem_req, 0);
      score();
    end
    @(negedge clk);
    check("ack_pulse", ack, 0);
    check("idle_busy", busy, 0);
    check("hold_fault", fault, v.fault);
    check("hold_flags", {psw, exc}, {v.psw, v.exc});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    vecs = '{
      '{0, 0, 16'h0010, 16'h0000, 1, 3,  16'hBEEF, 16'h0010, 2'b11, 16'h0000, 1, 16'hBEEF, 0, 2'd0, 0, 0},
      '{1, 1, 16'h0021, 16'h00A5, 1, 1,  16'h0000, 16'h0020, 2'b10, 16'hA5A5, 0, 16'h0000, 0, 2'd0, 0, 0},
      '{0, 0, 16'h0003, 16'h0000, 0, 0,  16'h0000, 16'h0000, 2'b00, 16'h0000, 1, 16'h0000, 1, 2'd1, 0, 0},
      '{0, 0, 16'hFFFC, 16'h0000, 0, 0,  16'h0000, 16'h0000, 2'b00, 16'h0000, 1, 16'h0000, 0, 2'd0, 1, 0},
      '{0, 1, 16'hFFFF, 16'h0000, 0, 0,  16'h0000, 16'h0000, 2'b00, 16'h0000, 1, 16'h0000, 0, 2'd0, 0, 1},
      '{0, 0, 16'h0040, 16'h0000, 1, 0,  16'h7777, 16'h0040, 2'b11, 16'h0000, 0, 16'h0000, 1, 2'd2, 0, 0},
      '{0, 0, 16'h0042, 16'h0000, 1, 15, 16'h1234, 16'h0042, 2'b11, 16'h0000, 1, 16'h1234, 0, 2'd0, 0, 0},
      '{0, 1, 16'h0031, 16'h0000, 1, 2,  16'hCD12, 16'h0030, 2'b10, 16'h0000, 1, 16'h00CD, 0, 2'd0, 0, 0},
      '{0, 1, 16'h0030, 16'h0000, 1, 1,  16'hCD12, 16'h0030, 2'b01, 16'h0000, 1, 16'h0012, 0, 2'd0, 0, 0},
      '{1, 0, 16'h0050, 16'h5A3C, 1, 2,  16'h0000, 16'h0050, 2'b11, 16'h5A3C, 0, 16'h0000, 0, 2'd0, 0, 0},
      '{1, 1, 16'h0007, 16'h1234, 1, 1,  16'h0000, 16'h0006, 2'b10, 16'h3434, 0, 16'h0000, 0, 2'd0, 0, 0},
      '{1, 0, 16'h0011, 16'h9999, 0, 0,  16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 16'h0000, 1, 2'd1, 0, 0},
      '{0, 1, 16'hFFFC, 16'h0000, 0, 0,  16'h0000, 16'h0000, 2'b00, 16'h0000, 1, 16'h0000, 0, 2'd0, 1, 0}
    };
    repeat (2) @(negedge clk);
    check_zero("reset");
    check("reset32", {w_ack, w_busy, w_mreq}, 0);
    rst = 0;
    for (int i = 0; i < 13; i++) run_vec(vecs[i]);
    @(negedge clk);
    req = 1; we = 0; byte_en = 0; addr = 16'h0060;
    @(negedge clk);
    req = 0;
    check("abort_wait_req", mem_req, 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_zero("abort");
    for (int k = 0; k < 3; k++) begin
      mem_rdy = 1;
      @(negedge clk);
      check("abort_no_ack", ack, 0);
    end
    mem_rdy = 0;
    run_vec(vecs[0]);
    w_req = 1; w_byte = 1; w_addr = 32'h0000_0007;
    @(negedge clk);
    w_req = 0;
    check("w32_req", w_mreq, 1);
    check("w32_lanes", w_lanes, 4'b1000);
    check("w32_addr", w_maddr, 32'h0000_0004);
    w_rdy = 1; w_mrd = 32'h1122_3344;
    @(negedge clk);
    w_rdy = 0;
    check("w32_ack", w_ack, 1);
    check("w32_rdata", w_rdata, 32'h0000_0011);
    check("w32_fault", w_fault, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
  WORD, 16, data/address width; multiple of 8, at least 16.
  LANES, WORD/8, byte lanes per word.
  EXC_RET, 16'hFFFF, exception-return magic address.
  PSW_ADDR, 16'hFFFC, PSW-mapped address.
  TIMEOUT, 15, maximum wait cycles for memRdy_i.
REQ-002 Ports SHALL be (name, direction, width, meaning), one per line; clocking SHALL use one clock, and reset SHALL be synchronous and active-high:
  clk_i  in  1  single clock.
  rst_i  in  1  synchronous active-high reset.
  req_i  in  1  CPU access request.
  we_i  in  1  1 = write, 0 = read.
  byteEn_i  in  1  1 = byte access, 0 = word access.
  addr_i  in  WORD  byte address.
  wdata_i  in  WORD  write data; byte writes use [7:0].
  busy_o  out  1  unit not in IDLE.
  ack_o  out  1  one-cycle completion pulse.
  rdata_o  out  WORD  read data, valid with ack_o.
  fault_o  out  1  access faulted, valid with ack_o.
  faultCode_o  out  2  0 none, 1 misaligned, 2 timeout.
  pswAddr_o  out  1  completed access targeted PSW_ADDR.
  excRet_o  out  1  completed access targeted EXC_RET.
  memReq_o  out  1  memory request, held until accepted.
  memWe_o  out  1  memory write.
  memAddr_o  out  WORD  word-aligned address (lane bits zeroed).
  memLanes_o  out  LANES  one-hot or all-ones lane enables.
  memWdata_o  out  WORD  lane-positioned write data.
  memRdata_i  in  WORD  memory read data.
  memRdy_i  in  1  memory accepts or completes the access.

Function
REQ-003 FSM states SHALL be IDLE, WAIT and DONE; the request SHALL be sampled only in IDLE, and req_i in any other state SHALL be ignored.
REQ-004 Lane index L SHALL be addr_i[$clog2(LANES)-1:0]; a word access with L != 0 SHALL be misaligned.
REQ-005 Misaligned access SHALL go IDLE->DONE with no memory request, fault_o=1, faultCode_o=1.
REQ-006 Access with addr_i==EXC_RET or addr_i==PSW_ADDR (checked after alignment) SHALL go IDLE->DONE with no memory request, fault_o=0, and the matching flag set; rdata_o=0.
REQ-007 Any other access SHALL go IDLE->WAIT; in WAIT, memReq_o=1 with address, lanes and data registered at acceptance.
REQ-008 memLanes_o SHALL be all ones for word accesses and one-hot bit L for byte accesses.
REQ-009 Byte writes SHALL replicate wdata_i[7:0] across all lanes on memWdata_o.
REQ-010 Byte reads SHALL return lane L zero-extended in rdata_o; word reads SHALL return memRdata_i unchanged.
REQ-011 In WAIT, memRdy_i=1 SHALL capture read data and move to DONE; memReq_o SHALL drop on the following cycle.
REQ-012 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without memRdy_i; reaching TIMEOUT SHALL move to DONE with fault_o=1, faultCode_o=2 and memReq_o deasserted.
REQ-013 memRdy_i in the same cycle the counter reaches TIMEOUT SHALL win: the access completes with no fault.
REQ-014 DONE SHALL last exactly one cycle with ack_o=1 and then return to IDLE; fault_o, faultCode_o, pswAddr_o, excRet_o and rdata_o SHALL hold until the next ack_o.
REQ-015 Latency: a special or misaligned access SHALL ack 1 cycle after acceptance; a memory access SHALL ack 1 cycle after the memRdy_i cycle, minimum 2 cycles after acceptance.
REQ-016 busy_o SHALL be 1 in WAIT and DONE.

Reset
REQ-017 rst_i SHALL force IDLE; every output SHALL be 0 and the counter SHALL be 0 from the next edge.
REQ-018 Reset during WAIT SHALL abort the access with no ack_o, and memReq_o SHALL be 0 from the next edge.

Structure
REQ-019 A shared package SHALL hold the state enum, the fault-code enum (FLT_NONE, FLT_ALIGN, FLT_TIMEOUT) and the EXC_RET/PSW_ADDR defaults.
REQ-020 Lane decode and byte steering SHALL be a combinational sub-module named lane_steer, parametrised by WORD.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  Word read at 0x0010, memRdy_i on the 3rd WAIT cycle, memRdata_i=0xBEEF -> ack_o with rdata_o=0xBEEF, fault_o=0, memLanes_o=2'b11.
  Byte write at 0x0021 with wdata_i=0x00A5 -> memAddr_o=0x0020, memLanes_o=2'b10, memWdata_o=0xA5A5.
  Word read at 0x0003 -> ack_o 1 cycle after acceptance, faultCode_o=1, memReq_o never asserted.
  Read at 0xFFFC, then at 0xFFFF -> pswAddr_o=1, then excRet_o=1; no memory request.
  memRdy_i held 0 -> ack_o with faultCode_o=2 after TIMEOUT WAIT cycles; memRdy_i on the TIMEOUT cycle -> no fault.
  rst_i in the 2nd WAIT cycle -> no ack_o, all outputs 0; a new request afterwards completes normally.
  WORD=32 build: byte read at 0x0007, memRdata_i=0x11223344 -> rdata_o=0x00000011, memLanes_o=4'b1000.
